// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams an NW-word bitstream MSB-first into a PAL configuration shift chain.
// Define PAL_CFG_LOADER_CRC_EN to add a CRC-8 (poly 0x07) over the shifted bits on chk_o.
module pal_cfg_loader #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 8,
   parameter int unsigned P = 8,
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic [W-1:0] word_data_i,
   input  logic         word_valid_i,
   output logic         word_ready_o,
   output logic         cfg_o,
   output logic         shift_en_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [7:0]   chk_o
);

   localparam int unsigned SrLen    = 2 * N * P + P * M;
   localparam int unsigned NumWords = (SrLen + W - 1) / W;
   localparam int unsigned LastBits = SrLen - (NumWords - 1) * W;
   localparam int unsigned BcW      = $clog2(W + 1);
   localparam int unsigned WcW      = (NumWords > 1) ? $clog2(NumWords) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StFin} state_e;

   state_e         state_q;
   logic [W-1:0]   word_q;
   logic [BcW-1:0] bit_cnt_q;
   logic [WcW-1:0] word_cnt_q;
   logic           cfg_q;
   logic           shift_en_q;
   logic           busy_q;
   logic           done_q;
   logic           last_word;

   assign last_word = (word_cnt_q == WcW'(NumWords - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         word_q     <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         cfg_q      <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (abort_i && (state_q != StIdle)) begin
         // Abort wins over word acceptance and shift completion; done_q was cleared at start.
         state_q    <= StIdle;
         word_q     <= '0;
         bit_cnt_q  <= '0;
         cfg_q      <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q    <= StLoad;
                  word_cnt_q <= '0;
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StLoad: begin
               if (word_valid_i) begin
                  state_q    <= StShift;
                  cfg_q      <= word_data_i[W-1];
                  word_q     <= word_data_i << 1;
                  shift_en_q <= 1'b1;
                  bit_cnt_q  <= last_word ? BcW'(LastBits) : BcW'(W);
               end
            end
            StShift: begin
               if (bit_cnt_q == BcW'(1)) begin
                  cfg_q      <= 1'b0;
                  shift_en_q <= 1'b0;
                  if (last_word) begin
                     state_q <= StFin;
                  end else begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                     state_q    <= StLoad;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  cfg_q     <= word_q[W-1];
                  word_q    <= word_q << 1;
               end
            end
            StFin: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         endcase
      end
   end

   assign word_ready_o = (state_q == StLoad);
   assign cfg_o        = cfg_q;
   assign shift_en_o   = shift_en_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

`ifdef PAL_CFG_LOADER_CRC_EN
   logic [7:0] chk_q;
   logic [7:0] chk_d;

   always_comb begin
      chk_d = {chk_q[6:0], 1'b0} ^ ((chk_q[7] ^ cfg_q) ? 8'h07 : 8'h00);
   end

   // Every bit presented with shift_en_o high enters the PAL chain, so it enters the CRC too.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chk_q <= 8'h00;
      end else if ((state_q == StIdle) && start_i) begin
         chk_q <= 8'h00;
      end else if (shift_en_q) begin
         chk_q <= chk_d;
      end
   end

   assign chk_o = chk_q;
`else
   assign chk_o = 8'h00;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Randomized self-checking bench for pal_cfg_loader (N=2, M=1, P=2, W=4: 10-bit chain, 3 words).
// Expected stream, CRC and DONE timing come from a bitstream-level reference model.
module tb_pal_cfg_loader;

   localparam int N      = 2;
   localparam int M      = 1;
   localparam int P      = 2;
   localparam int W      = 4;
   localparam int SR_LEN = 2 * N * P + P * M;
   localparam int NW     = (SR_LEN + W - 1) / W;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [W-1:0] word_data;
   logic         word_valid;
   logic         word_ready;
   logic         cfg;
   logic         shift_en;
   logic         busy;
   logic         done;
   logic [7:0]   chk;

   logic [W-1:0]      words [NW];
   int                stalls [NW];
   logic              ref_bits [$];
   logic [SR_LEN-1:0] got_vec;
   logic [7:0]        model_chk;

   int n_cmp = 0;
   int n_bad = 0;

   pal_cfg_loader #(
      .N(N),
      .M(M),
      .P(P),
      .W(W)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .word_data_i (word_data),
      .word_valid_i(word_valid),
      .word_ready_o(word_ready),
      .cfg_o       (cfg),
      .shift_en_o  (shift_en),
      .busy_o      (busy),
      .done_o      (done),
      .chk_o       (chk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Chain content in transmission order: word-major, MSB first, truncated to SR_LEN bits.
   task automatic build_ref();
      logic [7:0] c;
      logic       fb;
      ref_bits.delete();
      for (int k = 0; k < NW; k++) begin
         for (int b = W - 1; b >= 0; b--) begin
            if (k * W + (W - 1 - b) < SR_LEN) ref_bits.push_back(words[k][b]);
         end
      end
      c = 8'h00;
      foreach (ref_bits[i]) begin
         fb = c[7] ^ ref_bits[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
`ifdef PAL_CFG_LOADER_CRC_EN
      model_chk = c;
`else
      model_chk = 8'h00;
`endif
   endtask

   task automatic check_all_low(input string tag);
      check_eq({tag, "_ready"}, word_ready, 0);
      check_eq({tag, "_cfg"}, cfg, 0);
      check_eq({tag, "_shift_en"}, shift_en, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_chk"}, chk, 0);
   endtask

   // mode 0: complete load; 1: abort on 2nd bit of word 1; 2: async reset on 2nd bit of word 1.
   task automatic do_load(input bit poke, input bit abort_at_start, input int mode);
      logic got [$];
      int   cyc;
      int   widx;
      int   wait_cnt;
      int   exp_cyc;
      bit   poked;
      bit   accepted;
      bit   exp_ready;
      build_ref();
      exp_cyc = SR_LEN + NW + 1;
      for (int k = 0; k < NW; k++) exp_cyc += stalls[k];
      start      = 1'b1;
      abort      = abort_at_start;
      word_valid = 1'b0;
      step();
      start    = 1'b0;
      abort    = 1'b0;
      cyc      = 0;
      widx     = 0;
      wait_cnt = 0;
      poked    = 1'b0;
      check_eq("ready_after_start", word_ready, 1);
      check_eq("busy_after_start", busy, 1);
      check_eq("done_cleared", done, 0);
      while (!done && cyc < 200) begin
         if (mode != 0 && got.size() == W + 2) begin
            if (mode == 1) begin
               abort      = 1'b1;
               word_valid = 1'b1;
               step();
               abort = 1'b0;
               check_all_low("abort");
            end else begin
               #2 rst_n = 1'b0;
               #1;
               check_all_low("async_reset");
               #3 rst_n = 1'b1;
               step();
               check_all_low("post_reset");
            end
            word_valid = 1'b0;
            return;
         end
         accepted  = 1'b0;
         exp_ready = 1'b0;
         if (word_ready) begin
            if (widx < NW && wait_cnt >= stalls[widx]) begin
               word_valid = 1'b1;
               word_data  = words[widx];
               accepted   = 1'b1;
            end else begin
               word_valid = 1'b0;
               word_data  = W'($urandom);
               wait_cnt++;
               exp_ready  = 1'b1;
            end
         end else begin
            // Junk offered outside LOAD must never be consumed.
            word_valid = 1'b1;
            word_data  = W'($urandom);
         end
         if (poke && !poked && shift_en) begin
            start = 1'b1;
            poked = 1'b1;
         end
         step();
         start = 1'b0;
         cyc++;
         if (accepted) begin
            widx++;
            wait_cnt = 0;
            check_eq("ready_drop", word_ready, 0);
         end
         if (exp_ready) check_eq("ready_stall", word_ready, 1);
         if (shift_en) got.push_back(cfg);
         else check_eq("cfg_quiet", cfg, 0);
         if (!done) check_eq("busy_run", busy, 1);
`ifndef PAL_CFG_LOADER_CRC_EN
         check_eq("chk_zero", chk, 0);
`endif
      end
      word_valid = 1'b0;
      check_eq("done_seen", done, 1);
      check_eq("done_cycle", cyc, exp_cyc);
      check_eq("pulses", got.size(), SR_LEN);
      check_eq("busy_at_done", busy, 0);
      check_eq("chk", chk, model_chk);
      got_vec = '0;
      for (int i = 0; i < SR_LEN; i++) begin
         got_vec = {got_vec[SR_LEN-2:0], (i < got.size()) ? got[i] : 1'bx};
         check_eq("cfg_bit", (i < got.size()) ? got[i] : 1'bx, ref_bits[i]);
      end
   endtask

   task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      words[0] = a;
      words[1] = b;
      words[2] = c;
      for (int k = 0; k < NW; k++) stalls[k] = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      #1;
      check_all_low("reset");
      #23 rst_n = 1'b1;
      step();
      check_all_low("idle");

      set_words(4'hA, 4'h5, 4'hC);
      do_load(1'b0, 1'b0, 0);
      check_eq("stream_a5c", got_vec, 10'b1010010111);
      step();
      check_eq("done_hold", done, 1);

      set_words(4'hA, 4'h5, 4'hC);
      stalls[1] = 3;
      do_load(1'b0, 1'b0, 0);
      check_eq("stream_stall", got_vec, 10'b1010010111);

      set_words(4'hA, 4'h5, 4'hC);
      do_load(1'b0, 1'b0, 1);
      step();
      check_eq("abort_done_low", done, 0);
      do_load(1'b0, 1'b0, 0);
      check_eq("stream_after_abort", got_vec, 10'b1010010111);

      do_load(1'b1, 1'b1, 0);
      check_eq("stream_poke", got_vec, 10'b1010010111);

      do_load(1'b0, 1'b0, 2);
      do_load(1'b0, 1'b0, 0);
      check_eq("stream_after_reset", got_vec, 10'b1010010111);

      set_words(4'hF, 4'hF, 4'hF);
      do_load(1'b0, 1'b0, 0);
`ifdef PAL_CFG_LOADER_CRC_EN
      check_eq("crc_all_ones", chk, 8'hCC);
`else
      check_eq("crc_all_ones", chk, 8'h00);
`endif

      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < NW; k++) begin
            words[k]  = W'($urandom);
            stalls[k] = $urandom_range(0, 3);
         end
         do_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (t == 4) ? 1 : 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
